// File: rtl/i2c_target_link_if.sv
// Signal bundle for the I2C target link: the filtered bus lines, the
// open-drain SDA enable, and the byte-level handshake to the user logic.
interface i2c_target_link_if;
    logic       scl_i;
    logic       sda_i;
    logic       sda_oe;
    logic       start_o;
    logic       stop_o;
    logic       sel_o;
    logic       rw_o;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       rd_req;
    logic [7:0] rd_data;
    logic       busy;

    modport slave (
        input  scl_i, sda_i, rd_data,
        output sda_oe, start_o, stop_o, sel_o, rw_o, wr_valid, wr_data, rd_req, busy
    );

    modport master (
        output scl_i, sda_i, rd_data,
        input  sda_oe, start_o, stop_o, sel_o, rw_o, wr_valid, wr_data, rd_req, busy
    );
endinterface

// File: rtl/i2c_target_link.sv
// I2C target (slave) byte link. Detects START/STOP, matches a 7-bit address,
// ACKs address and write bytes, and serialises read bytes fetched through a
// request/data handshake. SCL is never stretched; SDA is only pulled low.
module i2c_target_link #(
    parameter logic [6:0] DEV_ADDR = 7'h50
) (
    input  logic             clk,
    input  logic             rstn,
    i2c_target_link_if.slave bus
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ADDR      = 3'd1;
    localparam logic [2:0] ADDR_ACK  = 3'd2;
    localparam logic [2:0] WRITE     = 3'd3;
    localparam logic [2:0] WRITE_ACK = 3'd4;
    localparam logic [2:0] READ      = 3'd5;
    localparam logic [2:0] READ_ACK  = 3'd6;

    logic [2:0] state_q,   state_d;
    logic [2:0] bitCnt_q,  bitCnt_d;
    logic [7:0] shift_q,   shift_d;
    logic       sdaOe_q,   sdaOe_d;
    logic       ackPend_q, ackPend_d;
    logic       start_q,   start_d;
    logic       stop_q,    stop_d;
    logic       sel_q,     sel_d;
    logic       rw_q,      rw_d;
    logic       wrValid_q, wrValid_d;
    logic [7:0] wrData_q,  wrData_d;
    logic       rdReq_q,   rdReq_d;
    logic       rdLoad_q;
    logic       scl_q,     sda_q;

    logic       sclRise;
    logic       sclFall;
    logic       startCond;
    logic       stopCond;
    logic [7:0] shiftIn;

    assign sclRise   = bus.scl_i & ~scl_q;
    assign sclFall   = ~bus.scl_i & scl_q;
    assign startCond = bus.scl_i & scl_q & sda_q & ~bus.sda_i;
    assign stopCond  = bus.scl_i & scl_q & ~sda_q & bus.sda_i;
    assign shiftIn   = {shift_q[6:0], bus.sda_i};

    // Next-state logic: bus conditions first, then per-state SCL edge actions.
    always_comb begin
        state_d   = state_q;
        bitCnt_d  = bitCnt_q;
        shift_d   = shift_q;
        sdaOe_d   = sdaOe_q;
        ackPend_d = ackPend_q;
        rw_d      = rw_q;
        wrData_d  = wrData_q;
        start_d   = 1'b0;
        stop_d    = 1'b0;
        sel_d     = 1'b0;
        wrValid_d = 1'b0;
        rdReq_d   = 1'b0;

        if (startCond) begin
            start_d   = 1'b1;
            state_d   = ADDR;
            bitCnt_d  = 3'd0;
            sdaOe_d   = 1'b0;
            ackPend_d = 1'b0;
        end else if (stopCond) begin
            stop_d    = 1'b1;
            state_d   = IDLE;
            sdaOe_d   = 1'b0;
            ackPend_d = 1'b0;
        end else begin
            if (rdLoad_q) begin
                shift_d = bus.rd_data;
            end
            case (state_q)
                ADDR: begin
                    if (ackPend_q) begin
                        if (sclFall) begin
                            sdaOe_d   = 1'b1;
                            state_d   = ADDR_ACK;
                            ackPend_d = 1'b0;
                        end
                    end else if (sclRise) begin
                        shift_d  = shiftIn;
                        bitCnt_d = bitCnt_q + 3'd1;
                        if (bitCnt_q == 3'd7) begin
                            if (shiftIn[7:1] == DEV_ADDR) begin
                                sel_d     = 1'b1;
                                rw_d      = shiftIn[0];
                                rdReq_d   = shiftIn[0];
                                ackPend_d = 1'b1;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                    end
                end
                ADDR_ACK: begin
                    if (sclFall) begin
                        if (rw_q) begin
                            state_d  = READ;
                            sdaOe_d  = ~shift_q[7];
                            shift_d  = {shift_q[6:0], 1'b0};
                            bitCnt_d = 3'd1;
                        end else begin
                            state_d  = WRITE;
                            sdaOe_d  = 1'b0;
                            bitCnt_d = 3'd0;
                        end
                    end
                end
                WRITE: begin
                    if (ackPend_q) begin
                        if (sclFall) begin
                            sdaOe_d   = 1'b1;
                            state_d   = WRITE_ACK;
                            ackPend_d = 1'b0;
                        end
                    end else if (sclRise) begin
                        shift_d  = shiftIn;
                        bitCnt_d = bitCnt_q + 3'd1;
                        if (bitCnt_q == 3'd7) begin
                            wrValid_d = 1'b1;
                            wrData_d  = shiftIn;
                            ackPend_d = 1'b1;
                        end
                    end
                end
                WRITE_ACK: begin
                    if (sclFall) begin
                        sdaOe_d = 1'b0;
                        state_d = WRITE;
                    end
                end
                READ: begin
                    if (sclFall) begin
                        if (bitCnt_q == 3'd0) begin
                            sdaOe_d   = 1'b0;
                            state_d   = READ_ACK;
                            ackPend_d = 1'b0;
                        end else begin
                            sdaOe_d  = ~shift_q[7];
                            shift_d  = {shift_q[6:0], 1'b0};
                            bitCnt_d = bitCnt_q + 3'd1;
                        end
                    end
                end
                READ_ACK: begin
                    if (ackPend_q) begin
                        if (sclFall) begin
                            state_d   = READ;
                            sdaOe_d   = ~shift_q[7];
                            shift_d   = {shift_q[6:0], 1'b0};
                            bitCnt_d  = 3'd1;
                            ackPend_d = 1'b0;
                        end
                    end else if (sclRise) begin
                        if (!bus.sda_i) begin
                            rdReq_d   = 1'b1;
                            ackPend_d = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Previous-cycle SCL/SDA levels for edge and bus-condition detection.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= bus.scl_i;
            sda_q <= bus.sda_i;
        end
    end

    // Protocol state, shift path and registered outputs.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q   <= IDLE;
            bitCnt_q  <= 3'd0;
            shift_q   <= 8'h00;
            sdaOe_q   <= 1'b0;
            ackPend_q <= 1'b0;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            sel_q     <= 1'b0;
            rw_q      <= 1'b0;
            wrValid_q <= 1'b0;
            wrData_q  <= 8'h00;
            rdReq_q   <= 1'b0;
            rdLoad_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitCnt_q  <= bitCnt_d;
            shift_q   <= shift_d;
            sdaOe_q   <= sdaOe_d;
            ackPend_q <= ackPend_d;
            start_q   <= start_d;
            stop_q    <= stop_d;
            sel_q     <= sel_d;
            rw_q      <= rw_d;
            wrValid_q <= wrValid_d;
            wrData_q  <= wrData_d;
            rdReq_q   <= rdReq_d;
            rdLoad_q  <= rdReq_q;
        end
    end

    assign bus.sda_oe   = sdaOe_q;
    assign bus.start_o  = start_q;
    assign bus.stop_o   = stop_q;
    assign bus.sel_o    = sel_q;
    assign bus.rw_o     = rw_q;
    assign bus.wr_valid = wrValid_q;
    assign bus.wr_data  = wrData_q;
    assign bus.rd_req   = rdReq_q;
    assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_target_link.sv
// Testbench for i2c_target_link: bit-bangs an I2C master against the target
// and compares against transaction-level expectations (address match, byte
// lists, pulse counts).
`timescale 1ns/1ps
module tb_i2c_target_link;

    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rstn;
    logic       mScl;
    logic       mSda;
    logic [7:0] rdData;

    int total = 0;
    int bad   = 0;

    i2c_target_link_if bus();

    assign bus.scl_i   = mScl;
    assign bus.sda_i   = mSda & ~bus.sda_oe;
    assign bus.rd_data = rdData;

    i2c_target_link #(.DEV_ADDR(7'h50)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int         startCnt = 0;
    int         stopCnt = 0;
    int         selCnt = 0;
    int         rdReqCnt = 0;
    int         timingBad = 0;
    int         selRdBad = 0;
    int         oeBad = 0;
    int         sclHigh = 0;
    logic       lastRw = 1'b0;
    logic       prevOe = 1'b0;
    logic       prevScl = 1'b1;
    logic [7:0] wrGot[$];

    // Event monitor sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (rstn) begin
            sclHigh = 0;
        end else begin
            sclHigh = bus.scl_i ? sclHigh + 1 : 0;
            if (bus.start_o) startCnt++;
            if (bus.stop_o) stopCnt++;
            if (bus.rd_req) rdReqCnt++;
            if (bus.sel_o) begin
                selCnt++;
                lastRw = bus.rw_o;
                if (bus.rd_req !== bus.rw_o) selRdBad++;
                if (sclHigh != 1) timingBad++;
            end
            if (bus.wr_valid) begin
                wrGot.push_back(bus.wr_data);
                if (sclHigh != 1) timingBad++;
            end
            if (bus.sda_oe !== prevOe && prevScl && bus.scl_i && !bus.start_o && !bus.stop_o)
                oeBad++;
        end
        prevOe  = bus.sda_oe;
        prevScl = bus.scl_i;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic i2cStart();
        mSda = 1'b1; waitClk(H);
        mScl = 1'b1; waitClk(H);
        mSda = 1'b0; waitClk(H);
        mScl = 1'b0; waitClk(H);
    endtask

    task automatic i2cStop();
        mSda = 1'b0; waitClk(H);
        mScl = 1'b1; waitClk(H);
        mSda = 1'b1; waitClk(H);
    endtask

    task automatic applyStimulus(input logic b, input bit glitch, output logic line);
        if (glitch) begin
            mSda = ~b; waitClk(1);
            mSda = b;  waitClk(1);
            mSda = ~b; waitClk(1);
        end
        mSda = b; waitClk(H);
        mScl = 1'b1; waitClk(H / 2);
        line = bus.sda_i;
        waitClk(H - H / 2);
        mScl = 1'b0; waitClk(1);
    endtask

    task automatic writeByte(input logic [7:0] b, input bit glitch, output logic acked, output logic busy8);
        logic line;
        for (int i = 7; i >= 0; i--) applyStimulus(b[i], glitch, line);
        busy8 = bus.busy;
        applyStimulus(1'b1, 1'b0, line);
        acked = ~line;
    endtask

    task automatic readByte(output logic [7:0] b, input bit ack);
        logic line;
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(1'b1, 1'b0, line);
            b[i] = line;
        end
        applyStimulus(~ack, 1'b0, line);
    endtask

    task automatic runTransfer(input string tag, input logic [7:0] addrByte, input int n,
                               input logic [7:0] data [4]);
        bit         match;
        logic       acked;
        logic       busy8;
        logic [7:0] got;
        int         s0, p0, sel0, rq0;
        match = (addrByte[7:1] == 7'h50);
        wrGot.delete();
        s0 = startCnt; p0 = stopCnt; sel0 = selCnt; rq0 = rdReqCnt;
        if (addrByte[0]) rdData = data[0];
        i2cStart();
        writeByte(addrByte, 1'b0, acked, busy8);
        checkOutput($sformatf("%s_addr_ack", tag), acked, match);
        checkOutput($sformatf("%s_busy_after_addr", tag), busy8, match);
        checkOutput($sformatf("%s_sel_count", tag), selCnt - sel0, match ? 1 : 0);
        if (match) begin
            checkOutput($sformatf("%s_rw", tag), lastRw, addrByte[0]);
            if (!addrByte[0]) begin
                for (int k = 0; k < n; k++) begin
                    writeByte(data[k], 1'b0, acked, busy8);
                    checkOutput($sformatf("%s_data_ack%0d", tag, k), acked, 1);
                end
                checkOutput($sformatf("%s_wr_count", tag), wrGot.size(), n);
                for (int k = 0; k < n; k++)
                    if (k < wrGot.size())
                        checkOutput($sformatf("%s_wr_data%0d", tag, k), wrGot[k], data[k]);
            end else begin
                for (int k = 0; k < n; k++) begin
                    if (k + 1 < n) rdData = data[k + 1];
                    readByte(got, k + 1 < n);
                    checkOutput($sformatf("%s_rd_byte%0d", tag, k), got, data[k]);
                end
                checkOutput($sformatf("%s_rd_req_count", tag), rdReqCnt - rq0, n);
                checkOutput($sformatf("%s_busy_after_nack", tag), bus.busy, 0);
            end
        end else begin
            checkOutput($sformatf("%s_wr_none", tag), wrGot.size(), 0);
        end
        i2cStop();
        checkOutput($sformatf("%s_start_count", tag), startCnt - s0, 1);
        checkOutput($sformatf("%s_stop_count", tag), stopCnt - p0, 1);
    endtask

    initial begin
        logic [7:0] d [4];
        logic       acked;
        logic       busy8;
        logic       line;
        logic [7:0] rb;
        logic [6:0] a7;
        int         s0, p0;

        rstn = 1'b1; mScl = 1'b1; mSda = 1'b1; rdData = 8'h00;
        waitClk(3);
        checkOutput("rst_sda_oe",   bus.sda_oe,   0);
        checkOutput("rst_busy",     bus.busy,     0);
        checkOutput("rst_start",    bus.start_o,  0);
        checkOutput("rst_stop",     bus.stop_o,   0);
        checkOutput("rst_sel",      bus.sel_o,    0);
        checkOutput("rst_rw",       bus.rw_o,     0);
        checkOutput("rst_wr_valid", bus.wr_valid, 0);
        checkOutput("rst_wr_data",  bus.wr_data,  8'h00);
        checkOutput("rst_rd_req",   bus.rd_req,   0);
        rstn = 1'b0;
        waitClk(3);

        d = '{8'h12, 8'h34, 8'h00, 8'h00};
        runTransfer("write2", 8'hA0, 2, d);

        d = '{8'h77, 8'h00, 8'h00, 8'h00};
        runTransfer("nomatch", 8'hA2, 1, d);

        d = '{8'h5A, 8'hC3, 8'h00, 8'h00};
        runTransfer("read2", 8'hA1, 2, d);

        // Repeated START in the middle of a write byte.
        wrGot.delete();
        s0 = startCnt;
        i2cStart();
        writeByte(8'hA0, 1'b0, acked, busy8);
        checkOutput("rs_addr_ack", acked, 1);
        for (int i = 0; i < 4; i++) applyStimulus(i[0], 1'b0, line);
        i2cStart();
        checkOutput("rs_start_count", startCnt - s0, 2);
        checkOutput("rs_no_wr_valid", wrGot.size(), 0);
        rb = 8'($urandom_range(0, 255));
        writeByte(8'hA0, 1'b0, acked, busy8);
        checkOutput("rs_addr2_ack", acked, 1);
        writeByte(rb, 1'b0, acked, busy8);
        checkOutput("rs_data_ack", acked, 1);
        checkOutput("rs_wr_count", wrGot.size(), 1);
        if (wrGot.size() > 0) checkOutput("rs_wr_data", wrGot[0], rb);
        i2cStop();

        // SDA wiggling while SCL is low must not look like START/STOP.
        wrGot.delete();
        s0 = startCnt; p0 = stopCnt;
        i2cStart();
        writeByte(8'hA0, 1'b0, acked, busy8);
        writeByte(8'hB6, 1'b1, acked, busy8);
        checkOutput("glitch_data_ack", acked, 1);
        checkOutput("glitch_start_count", startCnt - s0, 1);
        checkOutput("glitch_stop_count", stopCnt - p0, 0);
        checkOutput("glitch_wr_count", wrGot.size(), 1);
        if (wrGot.size() > 0) checkOutput("glitch_wr_data", wrGot[0], 8'hB6);
        i2cStop();

        // Reset while the target is pulling SDA low in a write ACK slot.
        i2cStart();
        writeByte(8'hA0, 1'b0, acked, busy8);
        for (int i = 7; i >= 0; i--) applyStimulus(1'b1, 1'b0, line);
        checkOutput("mid_oe_before_reset", bus.sda_oe, 1);
        rstn = 1'b1;
        #1;
        checkOutput("mid_oe_async_release", bus.sda_oe, 0);
        mSda = 1'b1;
        waitClk(1);
        mScl = 1'b1;
        waitClk(2);
        checkOutput("mid_busy",     bus.busy,     0);
        checkOutput("mid_wr_data",  bus.wr_data,  8'h00);
        checkOutput("mid_rw",       bus.rw_o,     0);
        checkOutput("mid_wr_valid", bus.wr_valid, 0);
        rstn = 1'b0;
        waitClk(3);
        d = '{8'hE1, 8'h0F, 8'h00, 8'h00};
        runTransfer("post_reset", 8'hA0, 2, d);

        // Randomised transactions against the address/byte model.
        for (int t = 0; t < 8; t++) begin
            if ($urandom_range(0, 3) != 0) begin
                a7 = 7'h50;
            end else begin
                a7 = 7'($urandom_range(0, 127));
                if (a7 == 7'h50) a7 = 7'h51;
            end
            for (int k = 0; k < 4; k++) d[k] = 8'($urandom_range(0, 255));
            runTransfer($sformatf("rand%0d", t), {a7, 1'($urandom_range(0, 1))},
                        int'($urandom_range(1, 3)), d);
        end

        checkOutput("oe_only_scl_low", oeBad, 0);
        checkOutput("pulse_timing", timingBad, 0);
        checkOutput("sel_rd_req_pairing", selRdBad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_target_link.md
I2C_TARGET_LINK -- requirements
Module: i2c_target_link

Interface
REQ-001 Parameter DEV_ADDR, default 7'h50, 7-bit target address matched against the first byte after START.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-high.
REQ-004 scl_i  input  1  filtered, synchronised SCL level.
REQ-005 sda_i  input  1  filtered, synchronised SDA level.
REQ-006 sda_oe  output  1  1 = pull SDA low (open-drain), 0 = release.
REQ-007 start_o  output  1  one-cycle pulse on START or repeated START.
REQ-008 stop_o  output  1  one-cycle pulse on STOP.
REQ-009 sel_o  output  1  one-cycle pulse on address match; rw_o valid the same cycle.
REQ-010 rw_o  output  1  R/W bit of the last matched address byte, held until next match.
REQ-011 wr_valid  output  1  one-cycle pulse; wr_data holds a received write byte.
REQ-012 wr_data  output  8  last received write byte, held between pulses.
REQ-013 rd_req  output  1  one-cycle pulse requesting the next byte to transmit.
REQ-014 rd_data  input  8  transmit byte; sampled on the clk cycle after rd_req.
REQ-015 busy  output  1  1 whenever state is not IDLE.

Function
REQ-016 The block SHALL register scl_i/sda_i once (scl_q, sda_q); scl_rise = scl_i & ~scl_q, scl_fall = ~scl_i & scl_q.
REQ-017 START (sda falling while scl_i and scl_q high) SHALL, from any state including mid-byte, pulse start_o, clear the bit counter, release sda_oe and enter ADDR.
REQ-018 STOP (sda rising while scl_i and scl_q high) SHALL, from any state, pulse stop_o, release sda_oe and enter IDLE; START/STOP take priority over all scl edge actions.
REQ-019 States SHALL be IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK; a 3-bit counter counts bits 0..7 and wraps to 0 after the 8th.
REQ-020 ADDR: shift sda_i in MSB-first on each scl_rise; after the 8th bit, if byte[7:1]==DEV_ADDR pulse sel_o and load rw_o=byte[0], else enter IDLE with sda_oe never asserted.
REQ-021 On a match with rw_o=1, rd_req SHALL pulse in the same cycle as sel_o.
REQ-022 After a match, the next scl_fall SHALL assert sda_oe and enter ADDR_ACK; the following scl_fall SHALL release sda_oe and enter WRITE (rw=0) or READ (rw=1).
REQ-023 WRITE: shift 8 bits on scl_rise; in the cycle after the 8th scl_rise, wr_data SHALL update and wr_valid SHALL pulse; next scl_fall asserts sda_oe (WRITE_ACK); following scl_fall releases and returns to WRITE.
REQ-024 READ: on entry scl_fall and each subsequent scl_fall, sda_oe SHALL equal the inverse of the current shift MSB, shifting left; after 8 bits driven, the 8th-bit-ending scl_fall SHALL release sda_oe and enter READ_ACK.
REQ-025 READ_ACK: on scl_rise sample sda_i; 0 (ACK) pulses rd_req, then the next scl_fall enters READ driving the new byte's MSB; 1 (NACK) enters IDLE with sda_oe released.
REQ-026 rd_data SHALL be latched into the shift register exactly one clk after rd_req; no other rd_data sampling occurs.
REQ-027 sda_oe SHALL change only on scl_fall cycles, START, STOP or reset (never while SCL is high).
REQ-028 No clock stretching; SCL is never driven.

Reset
REQ-029 While rstn=1: state=IDLE, counter=0, shift=0, sda_oe=0, start_o=stop_o=sel_o=wr_valid=rd_req=0, rw_o=0, wr_data=8'h00, busy=0, scl_q=sda_q=1.
REQ-030 Reset asserted mid-transfer SHALL release sda_oe immediately (asynchronously); after release the block waits in IDLE for a fresh START.

Verification
REQ-031 START, addr byte 0xA0, data 0x12, 0x34, STOP -> start_o, sel_o rw_o=0, ACK low on 3 ACK slots, wr_valid twice with 0x12 then 0x34, stop_o.
REQ-032 START, addr 0xA2 -> no sel_o, sda_oe stays 0 in ACK slot, busy drops to 0 after 8th bit.
REQ-033 START, addr 0xA1, rd_data 0x5A then 0xC3, master ACK then NACK -> rd_req twice, SDA pattern 01011010 then 11000011, IDLE after NACK.
REQ-034 Repeated START after 4 bits of a write byte -> start_o, no wr_valid, new address byte accepted normally.
REQ-035 rstn pulsed while sda_oe=1 in WRITE_ACK -> sda_oe 0 same cycle, all outputs at reset values, next transaction from START completes correctly.
REQ-036 SDA toggled while SCL low in WRITE -> no start_o/stop_o, data bits unaffected.
